// File: rtl/ireg_pkg.sv
// Shared constants and helpers for the prefetching instruction register.
// Optional parity protection is enabled by defining IREG_PARITY_EN.
package ireg_pkg;

  localparam int IW_DEF    = 49;
  localparam int OW_DEF    = 48;
  localparam int SPLIT_DEF = 26;
  localparam int DEPTH_DEF = 4;

  localparam int DESTIMOD_LO = 0;
  localparam int DESTIMOD_HI = 1;

  localparam int PAR_W = 64;

  // True when the vector (word plus its parity bit) has odd parity.
  function automatic logic par_odd_ok(
    input logic [PAR_W-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/ireg_fifo.sv
// Prefetch queue: DEPTH-entry FIFO with push/pop/flush.
// Pointers wrap modulo DEPTH; count is held separately.
module ireg_fifo
  import ireg_pkg::*;
#(
  parameter int W     = IW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ireg_prefetch.sv
// Instruction register with prefetch queue and IOB override merge.
// Define IREG_PARITY_EN to add i_par input and sticky parity_err.
module ireg_prefetch
  import ireg_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int OW    = OW_DEF,
  parameter int SPLIT = SPLIT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IW-1:0]          i,
`ifdef IREG_PARITY_EN
  input  logic                   i_par,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OW-1:0]          iob,
  input  logic [1:0]             destimod,
  input  logic                   state_fetch,
  input  logic                   flush,
  output logic [IW-1:0]          ir,
  output logic                   ir_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   parity_err
);

`ifdef IREG_PARITY_EN
  localparam int FW = IW + 1;
`else
  localparam int FW = IW;
`endif

  logic [FW-1:0] q_din;
  logic [FW-1:0] q_head;
  logic          q_full;
  logic          q_empty;
  logic          use_q;
  logic          use_byp;
  logic          have_src;
  logic          fetch;
  logic          push;
  logic [IW-1:0] src;
  logic [IW-1:0] merged;

`ifdef IREG_PARITY_EN
  assign q_din = {i_par, i};
`else
  assign q_din = i;
`endif

  assign fetch    = state_fetch && !flush;
  assign use_q    = fetch && !q_empty;
  assign use_byp  = fetch && q_empty && in_valid;
  assign have_src = use_q || use_byp;
  // A bypassed word is consumed directly and never enters the queue.
  assign push     = in_valid && in_ready && !flush && !use_byp;
  assign in_ready = !q_full;
  assign src      = use_q ? q_head[IW-1:0] : i;

  ireg_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (use_q),
    .flush (flush),
    .din   (q_din),
    .head  (q_head),
    .count (count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    merged = src;
    if (destimod[DESTIMOD_HI]) begin
      merged[IW-1:OW]    = '0;
      merged[OW-1:SPLIT] = iob[OW-1:SPLIT];
    end
    if (destimod[DESTIMOD_LO]) begin
      merged[SPLIT-1:0] = iob[SPLIT-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      ir_valid <= 1'b0;
    end else if (state_fetch) begin
      ir_valid <= have_src;
      if (have_src) begin
        ir <= merged;
      end
    end
  end

`ifdef IREG_PARITY_EN
  logic src_par;
  logic par_ok;

  assign src_par = use_q ? q_head[IW] : i_par;
  assign par_ok  = par_odd_ok(PAR_W'({src_par, src}));

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (have_src && !par_ok) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/ireg_prefetch.md
# ireg_prefetch

Parametrised instruction register with a small prefetch queue in front of it. Control-memory words are buffered in a DEPTH-entry FIFO; on each `state_fetch` the head word is loaded into `ir`. The IOB-override merge (destimod) is applied at load time on a configurable field split. Sits between control-memory readout and the decode/dispatch logic, replacing the single-stage instruction register.

## Interface
Parameters:
- `IW`, 49, instruction width (`i`, `ir`).
- `OW`, 48, IOB width; requires `OW < IW`.
- `SPLIT`, 26, low/high override boundary; requires `0 < SPLIT < OW`.
- `DEPTH`, 4, prefetch queue entries; power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `i`  in  IW  control-memory word.
- `in_valid`  in  1  `i` is valid this cycle.
- `in_ready`  out  1  queue can accept a push.
- `iob`  in  OW  IOB override data.
- `destimod`  in  2  bit1 overrides the high field, bit0 overrides the low field.
- `state_fetch`  in  1  load `ir` this cycle.
- `flush`  in  1  discard all prefetched words.
- `ir`  out  IW  instruction register.
- `ir_valid`  out  1  `ir` holds a real instruction.
- `count`  out  $clog2(DEPTH)+1  queue occupancy.
- `parity_err`  out  1  sticky parity error (see Configuration).

## Operation
- **Push.** A word is pushed when `in_valid && in_ready && !flush`.
- **Fetch source.** On `state_fetch && !flush`, the source word is chosen in this order:
  - the queue head, if `count != 0` (pop);
  - otherwise `i`, if `in_valid` (bypass; the word is not written into the queue);
  - otherwise there is no source.
- **Merge on load.** With source `s`:
  - `ir[IW-1:OW] <= destimod[1] ? 0 : s[IW-1:OW]`
  - `ir[OW-1:SPLIT] <= destimod[1] ? iob[OW-1:SPLIT] : s[OW-1:SPLIT]`
  - `ir[SPLIT-1:0] <= destimod[0] ? iob[SPLIT-1:0] : s[SPLIT-1:0]`
  - `ir_valid <= 1`.
- **Fetch with no source.** `ir` holds its value, `ir_valid <= 0`, regardless of `destimod`.
- **No fetch.** `ir` and `ir_valid` hold.
- **Simultaneous push and pop.** `count` is unchanged; the pushed word goes to the tail.
- **Flush.**
  - `count <= 0` and pointers are cleared.
  - A push in the same cycle is dropped.
  - A fetch in the same cycle is not performed, and `ir_valid <= 0`.
  - `ir` data holds.
- **Pointers.** Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- **Reset.** `ir = 0`, `ir_valid = 0`, `count = 0`, pointers 0, `parity_err = 0`. Queue contents are don't-care. Reset overrides all other inputs.

## Timing
- `in_ready = (count != DEPTH)`, decoded from registers only. No same-cycle pop-through on full: when full, `in_ready` is low even if a pop occurs.
- Latency from push to a possible load is 1 cycle. Bypass loads `ir` on the same edge as `i` arrives.
- `ir`, `ir_valid`, `count` and `parity_err` all change only on the `clk` edge.
- `iob` and `destimod` are sampled only on the loading edge.

## Configuration
- **`IREG_PARITY_EN` defined:**
  - adds input port `i_par` (1 bit, odd parity over `i`);
  - each queue entry stores `i_par` alongside the word;
  - on every load, parity of the source word plus its stored or bypassed `i_par` is checked;
  - odd-parity failure sets `parity_err`, which is cleared only by `reset`;
  - the check is on the source word before merge.
- **Undefined:** no `i_par` port, no parity storage, `parity_err` tied 0.

## Structure
- Shared package `ireg_pkg`:
  - default IW/OW/SPLIT/DEPTH constants;
  - `destimod` bit indices (`DESTIMOD_LO = 0`, `DESTIMOD_HI = 1`);
  - parity helper function.
- One sub-module, `ireg_fifo`:
  - parametrised on width (IW, plus 1 with parity) and DEPTH;
  - push/pop/flush interface;
  - outputs head, count and full.
- The merge and load logic stays in the top level.

## Test plan
- **Reset.** Reset with `in_valid = 1` and `state_fetch = 1` -> next cycle `ir = 0`, `ir_valid = 0`, `count = 0`, `in_ready = 1`.
- **Fill and order.** Push 5 words A..E with no fetch, DEPTH = 4 -> `count = 4`, `in_ready = 0` after the 4th push, E not accepted. Then 4 fetches -> `ir` = A, B, C, D in order, and `count` ends at 0.
- **Bypass.** Queue empty, `in_valid = 1`, `i = 49'h1_2345_6789_ABCD`, `state_fetch = 1` -> `ir` equals that value next cycle, `count` stays 0.
- **Merge, high field.** Head = all ones, `destimod = 2'b10`, `iob = 0` -> `ir = 49'h0_0000_03FF_FFFF` (bit 48 = 0, bits [47:26] = 0, bits [25:0] all ones).
- **Merge, low field.** Same head, `destimod = 2'b01`, `iob = 48'h0` -> `ir = 49'h1_FFFF_FC00_0000`.
- **Flush.** With `count = 3`, `flush` is asserted together with push and fetch -> `count = 0`, `ir_valid = 0`, `ir` unchanged. A later fetch on an empty queue with no input keeps `ir_valid = 0`.
- **Parity** (`IREG_PARITY_EN` only). Push a word with wrong `i_par`, then fetch -> `parity_err = 1`, and it stays 1 through subsequent good loads until `reset`.
